// File: rtl/contador_arbitro.sv
// Round-robin arbiter that turns signed step bursts from NREQ clients into
// single-cycle acrescer/decrecer pulses for a shared counter, tracking its value.
module contador_arbitro #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int QW        = 4,
    parameter int RESET_VAL = 106,
    parameter int LIM_LO    = 0,
    parameter int LIM_HI    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          dir,
    input  logic [NREQ*QW-1:0]       qty,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     acrescer,
    output logic                     decrecer,
    output logic                     sat,
    output logic [QW-1:0]            passos,
    output logic [WIDTH-1:0]         contagem
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   pick;
    logic            found;
    logic            dir_q;
    logic [QW-1:0]   remaining;
    logic [QW-1:0]   steps;
    logic            sat_q;
    logic            do_grant, pulse_up, pulse_dn, hit_bound, finish;
    logic            at_hi, at_lo;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(last_q) + i) % NREQ]) begin
                found = 1'b1;
                pick  = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    assign at_hi = (contagem == WIDTH'(LIM_HI));
    assign at_lo = (contagem == WIDTH'(LIM_LO));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        pulse_up   = 1'b0;
        pulse_dn   = 1'b0;
        hit_bound  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    do_grant   = 1'b1;
                    state_next = STEP;
                end
            end
            STEP: begin
                if (remaining == '0) begin
                    state_next = DONE;
                end else if (dir_q ? at_hi : at_lo) begin
                    hit_bound  = 1'b1;
                    state_next = DONE;
                end else begin
                    pulse_up = dir_q;
                    pulse_dn = !dir_q;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The mirror moves on the same edge the pulse is raised, so it already
    // reflects whatever pulse the counter is about to see.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            acrescer  <= 1'b0;
            decrecer  <= 1'b0;
            sat       <= 1'b0;
            passos    <= '0;
            contagem  <= WIDTH'(RESET_VAL);
            last_q    <= IW'(NREQ - 1);
            dir_q     <= 1'b0;
            remaining <= '0;
            steps     <= '0;
            sat_q     <= 1'b0;
        end else begin
            acrescer <= pulse_up;
            decrecer <= pulse_dn;
            ack      <= '0;
            if (do_grant) begin
                grant_id  <= pick;
                last_q    <= pick;
                dir_q     <= dir[pick];
                remaining <= qty[int'(pick)*QW +: QW];
                steps     <= '0;
                sat_q     <= 1'b0;
                busy      <= 1'b1;
            end else if (state == IDLE) begin
                busy <= 1'b0;
            end
            if (pulse_up || pulse_dn) begin
                contagem  <= pulse_up ? contagem + WIDTH'(1) : contagem - WIDTH'(1);
                remaining <= remaining - QW'(1);
                steps     <= steps + QW'(1);
            end
            if (hit_bound) sat_q <= 1'b1;
            if (finish) begin
                ack    <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                sat    <= sat_q;
                passos <= steps;
            end
        end
    end
endmodule

// File: doc/contador_arbitro.md
Name: contador_arbitro

Overview:
- Sequencing controller that shares one up/down step counter (8-bit, one step per cycle via acrescer/decrecer, reset value 106) between NREQ requesters.
- Each requester asks for a signed burst: a direction plus a step count. The block grants requesters round-robin and drives single-cycle step pulses into the counter.
- It keeps a mirror of the counter value and stops bursts at programmable bounds.
- Sits between client logic and the Contador instance; it is the only driver of acrescer/decrecer.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, counter/mirror width
- QW, 4, step-count field width per requester
- RESET_VAL, 106, mirror value after reset; must equal the counter's reset value
- LIM_LO, 0, lowest value a burst may reach
- LIM_HI, 255, highest value a burst may reach

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request, held until ack
- dir  input  NREQ  per-requester direction, 1=up, 0=down; sampled at grant
- qty  input  NREQ*QW  per-requester step count, slice i = qty[i*QW +: QW]; sampled at grant
- ack  output  NREQ  one-hot, one-cycle completion pulse
- grant_id  output  $clog2(NREQ)  index of current/last granted requester
- busy  output  1  high from grant until the ack cycle inclusive
- acrescer  output  1  increment pulse to counter
- decrecer  output  1  decrement pulse to counter
- sat  output  1  valid with ack; burst truncated at a bound
- passos  output  QW  valid with ack; steps actually issued
- contagem  output  WIDTH  mirror value, including any pulse currently on acrescer/decrecer

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: rst sampled high at a clk edge sets the following.
  - ack=0, acrescer=0, decrecer=0, busy=0, sat=0, passos=0, grant_id=0
  - contagem=RESET_VAL, state=IDLE, round-robin pointer so requester 0 has highest priority
  - Reset mid-burst aborts it with no ack. System resets the counter at the same time.
- States: IDLE, STEP, DONE.
- IDLE:
  - If any req is high, pick the first requester at or after (last grant + 1) mod NREQ.
  - Latch its dir and qty into remaining. Set grant_id and busy. Go to STEP.
  - No req: stay in IDLE, outputs idle.
- STEP, evaluated each edge:
  - remaining==0: go to DONE.
  - Otherwise, if dir=1 and contagem==LIM_HI, or dir=0 and contagem==LIM_LO: set sat, go to DONE, no pulse.
  - Otherwise, assert acrescer (up) or decrecer (down) for one cycle. On the same edge: contagem ±1, remaining-1, passos+1.
  - Pulses are back-to-back: a qty=N burst with no bound hit gives N consecutive pulse cycles.
- DONE: ack[grant_id]=1 for one cycle with sat/passos valid. busy is still high this cycle. Next state is IDLE.
- Latency:
  - req seen in IDLE at edge k, first pulse high in cycle after edge k+1.
  - Unbounded burst of N steps: ack high in cycle after edge k+N+2.
  - qty=0: ack in cycle after edge k+2, no pulses, sat=0, passos=0.
- Invariants:
  - acrescer and decrecer are never high together.
  - No pulse is issued outside STEP.
  - contagem never leaves [LIM_LO, LIM_HI] through bursts.
  - Counter saida equals contagem one cycle later.
- req deasserted mid-burst is ignored; the burst completes and acks.
- req still high after ack is treated as a new request, and the round-robin pointer has moved past it.
- dir/qty changes after grant have no effect.
- sat, passos hold until the next ack.

Test Plan:
- Reset, req[1]=1 up qty=3 → acrescer high 3 consecutive cycles; ack[1] 1 cycle; passos=3, sat=0, contagem=109; counter saida=109.
- LIM_LO=100, req[0] down qty=10 from 106 → exactly 6 decrecer pulses; ack[0] with sat=1, passos=6, contagem=100.
- After reset, req[0] and req[2] raised together and held → grant order 0, 2, 0, 2; ack[0] precedes ack[2]; no cycle with both pulses high.
- req[3] qty=0 → ack[3] two cycles after grant edge; no acrescer/decrecer; passos=0.
- rst high during 2nd pulse of a qty=5 burst → next cycle all outputs zero, contagem=106, state IDLE, no ack.
- req[2] dropped one cycle after grant, qty=4 up → 4 pulses still issued, ack[2] asserted.
